// File: rtl/gpu_video_pkg.sv
// Shared video definitions: default 640x480@60 timing, derived totals and RGB444 layout.
package gpu_video_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned RGB_R_W = 4;
    localparam int unsigned RGB_G_W = 4;
    localparam int unsigned RGB_B_W = 4;
    localparam int unsigned RGB_W   = RGB_R_W + RGB_G_W + RGB_B_W;

    typedef struct packed {
        logic [RGB_R_W-1:0] r;
        logic [RGB_G_W-1:0] g;
        logic [RGB_B_W-1:0] b;
    } rgb444_t;

    // Bits needed for a counter running 0..total-1.
    function automatic int unsigned cnt_width(input int unsigned total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/video_timing.sv
// Raster counters with zero-latency active/sync/frame-start flags.
module video_timing
    import gpu_video_pkg::*;
#(
    parameter int unsigned h_active = H_ACTIVE,
    parameter int unsigned h_fp     = H_FP,
    parameter int unsigned h_sync   = H_SYNC,
    parameter int unsigned h_bp     = H_BP,
    parameter int unsigned v_active = V_ACTIVE,
    parameter int unsigned v_fp     = V_FP,
    parameter int unsigned v_sync   = V_SYNC,
    parameter int unsigned v_bp     = V_BP,
    localparam int unsigned h_total = h_active + h_fp + h_sync + h_bp,
    localparam int unsigned v_total = v_active + v_fp + v_sync + v_bp,
    localparam int unsigned h_w     = cnt_width(h_total),
    localparam int unsigned v_w     = cnt_width(v_total)
) (
    input  logic           pix_clk,
    input  logic           rst,
    output logic [h_w-1:0] h_cnt,
    output logic [v_w-1:0] v_cnt,
    output logic           active_c,
    output logic           hsync_c,
    output logic           vsync_c,
    output logic           frame_start_c
);

    localparam int unsigned h_sync_start = h_active + h_fp;
    localparam int unsigned h_sync_end   = h_active + h_fp + h_sync;
    localparam int unsigned v_sync_start = v_active + v_fp;
    localparam int unsigned v_sync_end   = v_active + v_fp + v_sync;

    // Line counter wraps every h_total; frame counter steps on each line wrap.
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == h_w'(h_total - 1)) begin
            h_cnt <= '0;
            if (v_cnt == v_w'(v_total - 1)) begin
                v_cnt <= '0;
            end else begin
                v_cnt <= v_cnt + v_w'(1);
            end
        end else begin
            h_cnt <= h_cnt + h_w'(1);
        end
    end

    assign active_c      = (h_cnt < h_w'(h_active)) && (v_cnt < v_w'(v_active));
    assign hsync_c       = (h_cnt >= h_w'(h_sync_start)) && (h_cnt < h_w'(h_sync_end));
    assign vsync_c       = (v_cnt >= v_w'(v_sync_start)) && (v_cnt < v_w'(v_sync_end));
    assign frame_start_c = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: raster-driven RAM addressing with a two-stage pipeline that
// aligns the registered RAM data with DE, syncs and the frame-start pulse.
module vga_scanout
    import gpu_video_pkg::*;
#(
    parameter int unsigned ram_width  = 8,
    parameter int unsigned data_width = RGB_W,
    parameter int unsigned scale_log2 = 5,
    parameter int unsigned h_active   = H_ACTIVE,
    parameter int unsigned h_fp       = H_FP,
    parameter int unsigned h_sync     = H_SYNC,
    parameter int unsigned h_bp       = H_BP,
    parameter int unsigned v_active   = V_ACTIVE,
    parameter int unsigned v_fp       = V_FP,
    parameter int unsigned v_sync     = V_SYNC,
    parameter int unsigned v_bp       = V_BP
) (
    input  logic                  pix_clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [ram_width-1:0]  rd_add,
    input  logic [data_width-1:0] rd_data,
    output logic [data_width-1:0] rgb,
    output logic                  de,
    output logic                  hsync_n,
    output logic                  vsync_n,
    output logic                  frame_start
);

    localparam int unsigned k       = ram_width / 2;
    localparam int unsigned h_total = h_active + h_fp + h_sync + h_bp;
    localparam int unsigned v_total = v_active + v_fp + v_sync + v_bp;
    localparam int unsigned h_w     = cnt_width(h_total);
    localparam int unsigned v_w     = cnt_width(v_total);

    logic [h_w-1:0] h_cnt;
    logic [v_w-1:0] v_cnt;
    logic           active_c;
    logic           hsync_c;
    logic           vsync_c;
    logic           frame_start_c;

    logic           en_q;
    logic           act_d1;
    logic           hs_d1;
    logic           vs_d1;
    logic           fs_d1;

    video_timing #(
        .h_active (h_active),
        .h_fp     (h_fp),
        .h_sync   (h_sync),
        .h_bp     (h_bp),
        .v_active (v_active),
        .v_fp     (v_fp),
        .v_sync   (v_sync),
        .v_bp     (v_bp)
    ) u_timing (
        .pix_clk       (pix_clk),
        .rst           (rst),
        .h_cnt         (h_cnt),
        .v_cnt         (v_cnt),
        .active_c      (active_c),
        .hsync_c       (hsync_c),
        .vsync_c       (vsync_c),
        .frame_start_c (frame_start_c)
    );

    // Texel coordinates keep the low k bits only, so the image tiles across the screen.
    assign rd_add = {k'(v_cnt >> scale_log2), k'(h_cnt >> scale_log2)};

    // Stage 1 waits out the RAM read latency; stage 2 registers the visible outputs.
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            en_q        <= 1'b0;
            act_d1      <= 1'b0;
            hs_d1       <= 1'b0;
            vs_d1       <= 1'b0;
            fs_d1       <= 1'b0;
            rgb         <= '0;
            de          <= 1'b0;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            if (frame_start_c) begin
                en_q <= en;
            end
            act_d1      <= active_c;
            hs_d1       <= hsync_c;
            vs_d1       <= vsync_c;
            fs_d1       <= frame_start_c;
            rgb         <= (act_d1 && en_q) ? rd_data : '0;
            de          <= act_d1;
            hsync_n     <= ~hs_d1;
            vsync_n     <= ~vs_d1;
            frame_start <= fs_d1;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: default 640x480 instance checked over its first lines,
// plus a reduced-timing instance checked cycle by cycle over several frames.
module tb_vga_scanout;

    // Reduced timing: 28 x 15 raster, 4x4 image, 4x4 pixel texels.
    localparam int S_HT    = 28;
    localparam int S_VT    = 15;
    localparam int S_FRAME = S_HT * S_VT;

    logic        clk;
    logic        rst_d, rst_s;
    logic        en_d, en_s;

    logic [7:0]  rd_add_d;
    logic [11:0] rd_data_d, rgb_d;
    logic        de_d, hsync_n_d, vsync_n_d, fs_d;
    logic [11:0] mem_d [256];

    logic [3:0]  rd_add_s;
    logic [11:0] rd_data_s, rgb_s;
    logic        de_s, hsync_n_s, vsync_n_s, fs_s;
    logic [11:0] mem_s [16];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    vga_scanout u_dut_d (
        .pix_clk     (clk),
        .rst         (rst_d),
        .en          (en_d),
        .rd_add      (rd_add_d),
        .rd_data     (rd_data_d),
        .rgb         (rgb_d),
        .de          (de_d),
        .hsync_n     (hsync_n_d),
        .vsync_n     (vsync_n_d),
        .frame_start (fs_d)
    );

    vga_scanout #(
        .ram_width  (4),
        .data_width (12),
        .scale_log2 (2),
        .h_active   (20),
        .h_fp       (2),
        .h_sync     (3),
        .h_bp       (3),
        .v_active   (10),
        .v_fp       (1),
        .v_sync     (2),
        .v_bp       (2)
    ) u_dut_s (
        .pix_clk     (clk),
        .rst         (rst_s),
        .en          (en_s),
        .rd_add      (rd_add_s),
        .rd_data     (rd_data_s),
        .rgb         (rgb_s),
        .de          (de_s),
        .hsync_n     (hsync_n_s),
        .vsync_n     (vsync_n_s),
        .frame_start (fs_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read RAM models, one cycle of latency.
    always @(posedge clk) begin
        rd_data_d <= mem_d[rd_add_d];
        rd_data_s <= mem_s[rd_add_s];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
    endtask

    task automatic chk_rst_s();
        chk("s_rst_rgb",     32'(rgb_s),     32'h0);
        chk("s_rst_de",      32'(de_s),      32'h0);
        chk("s_rst_hsync_n", 32'(hsync_n_s), 32'h1);
        chk("s_rst_vsync_n", 32'(vsync_n_s), 32'h1);
        chk("s_rst_fs",      32'(fs_s),      32'h0);
    endtask

    // Cycle-accurate run of the reduced instance; cycle 0 is the first cycle after reset release.
    task automatic run_s(input int n, input int bf, input bit sched);
        int p, h, v, f, hc, vc, idx;
        int last_fs;
        bit act, hs, vs, fs;
        bit en_fr [8];
        logic [11:0] val;
        en_fr   = '{1, 1, 0, 1, 1, 1, 1, 1};
        last_fs = -1;
        for (int c = 0; c <= n; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            cyc = c;
            hc  = c % S_HT;
            vc  = (c / S_HT) % S_VT;
            chk("s_rd_add", 32'(rd_add_s), 32'(((vc >> 2) % 4) * 4 + (hc >> 2) % 4));
            if (c < 2) begin
                act = 0; hs = 0; vs = 0; fs = 0; val = '0;
            end else begin
                p   = c - 2;
                h   = p % S_HT;
                v   = (p / S_HT) % S_VT;
                f   = bf + p / S_FRAME;
                act = (h < 20) && (v < 10);
                hs  = (h >= 22) && (h < 25);
                vs  = (v >= 11) && (v < 13);
                fs  = (h == 0) && (v == 0);
                idx = ((v >> 2) % 4) * 4 + (h >> 2) % 4;
                val = (idx == 5 && f >= 4) ? 12'hF00 : 12'(idx);
                if (!(act && en_fr[f])) val = '0;
            end
            chk("s_rgb",     32'(rgb_s),     32'(val));
            chk("s_de",      32'(de_s),      32'(act));
            chk("s_hsync_n", 32'(hsync_n_s), 32'(!hs));
            chk("s_vsync_n", 32'(vsync_n_s), 32'(!vs));
            chk("s_fs",      32'(fs_s),      32'(fs));
            if (fs_s) begin
                if (last_fs >= 0) chk("s_fs_interval", 32'(c - last_fs), 32'(S_FRAME));
                last_fs = c;
            end
            if (sched) begin
                case (c)
                    560:     en_s = 1'b0;          // frame 1, line 5
                    980:     en_s = 1'b1;          // frame 2, line 5
                    1596:    mem_s[5] = 12'hF00;   // frame 3, vertical blanking
                    default: ;
                endcase
            end
        end
    endtask

    int de_cnt, first_de, hs_low;

    initial begin
        rst_d = 1'b1;
        rst_s = 1'b1;
        en_d  = 1'b1;
        en_s  = 1'b1;
        for (int i = 0; i < 256; i++) mem_d[i] = 12'(i);
        for (int i = 0; i < 16; i++)  mem_s[i] = 12'(i);
        repeat (3) @(posedge clk);
        #1;
        cyc = -1;
        chk("d_rst_rgb",     32'(rgb_d),     32'h0);
        chk("d_rst_de",      32'(de_d),      32'h0);
        chk("d_rst_hsync_n", 32'(hsync_n_d), 32'h1);
        chk("d_rst_vsync_n", 32'(vsync_n_d), 32'h1);
        chk("d_rst_fs",      32'(fs_d),      32'h0);
        chk_rst_s();

        // Default-timing instance: line 0 in detail, then the first line of texel row 1.
        rst_d    = 1'b0;
        de_cnt   = 0;
        first_de = -1;
        hs_low   = 0;
        for (int c = 0; c <= 25602; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            cyc = c;
            if (c <= 801) begin
                if (de_d) begin
                    de_cnt++;
                    if (first_de < 0) first_de = c;
                end
                if (c >= 2 && !hsync_n_d) hs_low++;
            end
            case (c)
                0:     chk("d_rd_add_0",   32'(rd_add_d), 32'h00);
                1:     chk("d_de_c1",      32'(de_d),     32'h0);
                2: begin
                    chk("d_fs_c2",  32'(fs_d),  32'h1);
                    chk("d_rgb_x0", 32'(rgb_d), 32'h000);
                end
                3:     chk("d_fs_c3",      32'(fs_d),     32'h0);
                32:    chk("d_rd_add_32",  32'(rd_add_d), 32'h01);
                33:    chk("d_rgb_x31",    32'(rgb_d),    32'h000);
                34:    chk("d_rgb_x32",    32'(rgb_d),    32'h001);
                400:   chk("d_vsync_n_l0", 32'(vsync_n_d), 32'h1);
                480:   chk("d_rd_add_480", 32'(rd_add_d), 32'h0F);
                512:   chk("d_rd_add_512", 32'(rd_add_d), 32'h00);
                513:   chk("d_rgb_x511",   32'(rgb_d),    32'h00F);
                514:   chk("d_rgb_x512",   32'(rgb_d),    32'h000);
                639:   chk("d_rd_add_639", 32'(rd_add_d), 32'h03);
                641:   chk("d_rgb_x639",   32'(rgb_d),    32'h003);
                642:   chk("d_de_c642",    32'(de_d),     32'h0);
                657:   chk("d_hsync_657",  32'(hsync_n_d), 32'h1);
                658:   chk("d_hsync_658",  32'(hsync_n_d), 32'h0);
                753:   chk("d_hsync_753",  32'(hsync_n_d), 32'h0);
                754:   chk("d_hsync_754",  32'(hsync_n_d), 32'h1);
                25600: chk("d_rd_add_l32", 32'(rd_add_d), 32'h10);
                25602: begin
                    chk("d_rgb_l32", 32'(rgb_d), 32'h010);
                    chk("d_de_l32",  32'(de_d),  32'h1);
                end
                default: ;
            endcase
        end
        chk("d_de_count",  32'(de_cnt),   32'd640);
        chk("d_first_de",  32'(first_de), 32'd2);
        chk("d_hsync_low", 32'(hs_low),   32'd96);

        // Reduced instance: en drop/raise, RAM update, then reset mid-line at h=12, v=6 of frame 4.
        rst_s = 1'b0;
        run_s(4 * S_FRAME + 6 * S_HT + 12, 0, 1'b1);
        rst_s = 1'b1;
        #1;
        cyc = -1;
        chk_rst_s();
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_rst_s();
        end
        rst_s = 1'b0;
        run_s(S_FRAME + 50, 5, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
